// File: rtl/wb_bitstream_loader.sv
// Byte-stream to Wishbone configuration loader.
// Packs bytes into LE words and writes them to BASE_ADDR onward.
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock, async active-low reset
//   start, abort, word_count  load control
//   in_valid/in_ready/in_data byte stream input
//   wbm_*                     Wishbone initiator (single-beat writes)
//   busy, done, error         status (FILL|REQ, DONE, ERR)
//   words_written             acknowledged writes in current/last load
module wb_bitstream_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_addr_o,
  output logic [31:0]      wbm_data_o,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ww_q, ww_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             rdy_q, cyc_q;
  logic             busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ww_d    = ww_q;
    tmo_d   = tmo_q;
    if (abort) begin
      // abort beats a same-cycle ack: that write is not counted
      state_d = S_IDLE;
      idx_d   = 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (word_count == '0) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = word_count;
              ww_d    = '0;
              addr_d  = BASE_ADDR;
              idx_d   = 2'd0;
              state_d = S_FILL;
            end
          end
        end
        S_FILL: begin
          if (in_valid) begin
            data_d[{idx_q, 3'b000} +: 8] = in_data;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              tmo_d   = 16'd0;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (wbm_ack_i) begin
            ww_d = ww_q + CNT_W'(1);
            if (ww_d == cnt_q) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 32'd4;
              idx_d   = 2'd0;
              state_d = S_FILL;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs are flops decoded from the next state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      data_q  <= 32'd0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      ww_q    <= '0;
      tmo_q   <= 16'd0;
      rdy_q   <= 1'b0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ww_q    <= ww_d;
      tmo_q   <= tmo_d;
      rdy_q   <= (state_d == S_FILL);
      cyc_q   <= (state_d == S_REQ);
      busy_q  <= (state_d == S_FILL) || (state_d == S_REQ);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign in_ready      = rdy_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = cyc_q;
  assign wbm_sel_o     = {4{cyc_q}};
  assign wbm_addr_o    = addr_q;
  assign wbm_data_o    = data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_wb_bitstream_loader.sv
// Bench for wb_bitstream_loader.
// Expected writes come from a byte-list reference model.
module tb_wb_bitstream_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_addr_o, wbm_data_o;
  logic        wbm_ack_i = 1'b0;
  logic        busy, done, error;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;
  logic [7:0] preset[$];

  wb_bitstream_loader #(
    .BASE_ADDR(BASE),
    .CNT_W(16),
    .ACK_TIMEOUT(4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .start(start),
    .abort(abort),
    .word_count(word_count),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_addr_o(wbm_addr_o),
    .wbm_data_o(wbm_data_o),
    .wbm_ack_i(wbm_ack_i),
    .busy(busy),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input int n);
    word_count = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_word(output logic [31:0] word, input int gap);
    logic [7:0] b;
    int t;
    word = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
      if (preset.size() > 0) b = preset.pop_front();
      else b = 8'($urandom);
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("in_ready_fill", in_ready, 1);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
      word = word | (32'(b) << (8 * i));
    end
  endtask

  task automatic wait_cyc();
    int t = 0;
    while (wbm_cyc_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("cyc_rise", wbm_cyc_o, 1);
  endtask

  task automatic req_phase(input logic [31:0] ea, input logic [31:0] ed,
                           input int lat);
    int l;
    wait_cyc();
    chk("addr", wbm_addr_o, ea);
    chk("data", wbm_data_o, ed);
    chk("sel", wbm_sel_o, 4'hF);
    chk("we", wbm_we_o, 1);
    chk("in_ready_req", in_ready, 0);
    chk("busy_req", busy, 1);
    l = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
    repeat (l) begin
      @(negedge clk);
      chk("stb_hold", wbm_stb_o, 1);
      chk("data_hold", wbm_data_o, ed);
      chk("addr_hold", wbm_addr_o, ea);
    end
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("cyc_drop", wbm_cyc_o, 0);
  endtask

  task automatic do_load(input int n, input int gap, input int lat);
    logic [31:0] w;
    start_load(n);
    for (int i = 0; i < n; i++) begin
      feed_word(w, gap);
      req_phase(BASE + 32'(4 * i), w, lat);
    end
    chk("done", done, 1);
    chk("busy_done", busy, 0);
    chk("ww", words_written, 16'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    chk("rst_addr", wbm_addr_o, BASE);
    chk("rst_data", wbm_data_o, 0);
    chk("rst_flags", {in_ready, busy, done, error}, 0);
    chk("rst_ww", words_written, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, ack on second REQ cycle
    preset = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(1, 0, 1);

    // three words with gaps and random ack latency
    do_load(3, 2, -1);

    // random loads
    for (int r = 0; r < 3; r++) do_load($urandom_range(4, 1), 2, -1);

    // no ack: timeout after 4 REQ cycles
    start_load(1);
    feed_word(w, 1);
    wait_cyc();
    cnt = 0;
    while (wbm_cyc_o === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_cycles", cnt, 4);
    chk("tmo_error", error, 1);
    chk("tmo_ww", words_written, 0);
    chk("tmo_busy", busy, 0);
    do_load(1, 0, 2);
    chk("err_clear", error, 0);

    // zero words
    start_load(0);
    chk("zero_done", done, 1);
    chk("zero_rdy", in_ready, 0);
    cnt = 0;
    repeat (4) begin
      if (wbm_cyc_o !== 1'b0 || in_ready !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("zero_quiet", cnt, 0);

    // abort coincident with ack on word 2 of 3
    start_load(3);
    feed_word(w, 0);
    req_phase(BASE, w, 0);
    feed_word(w, 1);
    wait_cyc();
    chk("ab_addr", wbm_addr_o, BASE + 32'd4);
    wbm_ack_i = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    abort = 1'b0;
    chk("ab_cyc", wbm_cyc_o, 0);
    chk("ab_flags", {in_ready, busy, done, error}, 0);
    chk("ab_ww", words_written, 1);
    in_valid = 1'b1;
    cnt = 0;
    repeat (8) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (wbm_cyc_o !== 1'b0 || in_ready !== 1'b0) cnt++;
    end
    in_valid = 1'b0;
    chk("ab_quiet", cnt, 0);

    // async reset mid-REQ
    start_load(2);
    feed_word(w, 0);
    wait_cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc", wbm_cyc_o, 0);
    chk("ar_stb", wbm_stb_o, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", wbm_addr_o, BASE);
    @(negedge clk);
    chk("ar_hold_addr", wbm_addr_o, BASE);
    chk("ar_hold_ww", words_written, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_after", {wbm_cyc_o, in_ready, busy, done, error}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
